// File: rtl/pipe_sequencer.sv
// pipe_sequencer: in-order issue pipeline with clock-enable divider,
// RAW hazard interlock, external stall, partial flush and hazard counter.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   clk_enable          divider tick; stage registers move only on it
//   issue_*             offered instruction payload, registers and handshake
//   ext_stall, flush    freeze all stages / kill FLUSH_STAGE youngest stages
//   stage_valid, stage_mc/data/pc   per-stage state, stage k at [k*W +: W]
//   hazard, hazard_cycles           RAW interlock and saturating lost-tick count
module pipe_sequencer #(
   parameter int STAGES      = 4,
   parameter int MC_W        = 25,
   parameter int DATA_W      = 25,
   parameter int PC_W        = 30,
   parameter int RA_W        = 5,
   parameter int CE_DIV      = 2,
   parameter int FLUSH_STAGE = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     clk_enable,
   input  logic                     issue_valid,
   output logic                     issue_ready,
   input  logic [MC_W-1:0]          issue_mc,
   input  logic [DATA_W-1:0]        issue_data,
   input  logic [PC_W-1:0]          issue_pc,
   input  logic [RA_W-1:0]          issue_rs1,
   input  logic [RA_W-1:0]          issue_rs2,
   input  logic [RA_W-1:0]          issue_rd,
   input  logic [1:0]               issue_rs_use,
   input  logic                     issue_rd_we,
   input  logic                     ext_stall,
   input  logic                     flush,
   output logic [STAGES-1:0]        stage_valid,
   output logic [STAGES*MC_W-1:0]   stage_mc,
   output logic [STAGES*DATA_W-1:0] stage_data,
   output logic [STAGES*PC_W-1:0]   stage_pc,
   output logic                     hazard,
   output logic [15:0]              hazard_cycles
);

   localparam int CW = 5;
   localparam logic [CW-1:0] DIV_MAX = CW'(CE_DIV - 1);

   typedef struct packed {
      logic [MC_W-1:0]   mc;
      logic [DATA_W-1:0] data;
      logic [PC_W-1:0]   pc;
      logic [RA_W-1:0]   rd;
      logic              rd_we;
   } slot_t;

   logic [CW-1:0]           div_cnt;
   logic                    tick;
   logic                    hz;
   logic                    fire;
   logic [15:0]             hz_cnt;
   logic [STAGES-1:0]       vld;
   logic [STAGES-1:0]       nxt_vld;
   slot_t [STAGES-1:0]      slot;
   slot_t [STAGES-1:0]      nxt_slot;
   slot_t                   new_slot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_MAX) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick       = (div_cnt == DIV_MAX);
   assign clk_enable = tick;

   // Writeback stage is excluded: its result is visible to the reader.
   always_comb begin
      hz = 1'b0;
      for (int k = 0; k < STAGES - 1; k++) begin
         if (vld[k] && slot[k].rd_we && (slot[k].rd != '0)) begin
            if (issue_rs_use[0] && (issue_rs1 == slot[k].rd)) hz = 1'b1;
            if (issue_rs_use[1] && (issue_rs2 == slot[k].rd)) hz = 1'b1;
         end
      end
   end

   assign hazard      = hz;
   assign issue_ready = tick & ~hz & ~ext_stall & ~flush;
   assign fire        = issue_valid & issue_ready;

   always_comb begin
      new_slot       = '0;
      new_slot.mc    = issue_mc;
      new_slot.data  = issue_data;
      new_slot.pc    = issue_pc;
      new_slot.rd    = issue_rd;
      new_slot.rd_we = issue_rd_we;
   end

   // Killed stages become bubbles even under stall; a stage fed from a
   // killed stage also receives a bubble.
   always_comb begin
      nxt_vld  = vld;
      nxt_slot = slot;
      for (int k = 0; k < STAGES; k++) begin
         if (flush && (k < FLUSH_STAGE)) begin
            nxt_vld[k]  = 1'b0;
            nxt_slot[k] = '0;
         end else if (ext_stall) begin
            nxt_vld[k]  = vld[k];
            nxt_slot[k] = slot[k];
         end else if (k == 0) begin
            nxt_vld[k]  = fire;
            nxt_slot[k] = fire ? new_slot : '0;
         end else if (flush && ((k - 1) < FLUSH_STAGE)) begin
            nxt_vld[k]  = 1'b0;
            nxt_slot[k] = '0;
         end else begin
            nxt_vld[k]  = vld[k-1];
            nxt_slot[k] = slot[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= '0;
         slot <= '0;
      end else if (tick) begin
         vld  <= nxt_vld;
         slot <= nxt_slot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hz_cnt <= '0;
      end else if (tick && issue_valid && hz && !ext_stall && !flush
                   && (hz_cnt != 16'hFFFF)) begin
         hz_cnt <= hz_cnt + 16'd1;
      end
   end

   assign hazard_cycles = hz_cnt;
   assign stage_valid   = vld;

   for (genvar g = 0; g < STAGES; g++) begin : g_out
      assign stage_mc[g*MC_W +: MC_W]       = slot[g].mc;
      assign stage_data[g*DATA_W +: DATA_W] = slot[g].data;
      assign stage_pc[g*PC_W +: PC_W]       = slot[g].pc;
   end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of pipeline stages s0..s(STAGES-1); legal range 2..8.
REQ-002 SHALL have parameter MC_W, default 25, microcode word width.
REQ-003 SHALL have parameter DATA_W, default 25, instruction-data width.
REQ-004 SHALL have parameter PC_W, default 30, word-address PC width.
REQ-005 SHALL have parameter RA_W, default 5, register address width.
REQ-006 SHALL have parameter CE_DIV, default 2, clock-enable divide ratio; legal range 1..16.
REQ-007 SHALL have parameter FLUSH_STAGE, default 2, count of youngest stages killed by flush; legal range 1..STAGES.
REQ-008 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-009 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port clk_enable  output  1  pipeline advance tick.
REQ-011 SHALL have port issue_valid  input  1  decoded instruction offered.
REQ-012 SHALL have port issue_ready  output  1  instruction accepted on this tick.
REQ-013 SHALL have port issue_mc / issue_data / issue_pc  input  MC_W / DATA_W / PC_W  payload.
REQ-014 SHALL have port issue_rs1, issue_rs2, issue_rd  input  RA_W each  source/destination registers.
REQ-015 SHALL have port issue_rs_use  input  2  bit0 rs1 read, bit1 rs2 read.
REQ-016 SHALL have port issue_rd_we  input  1  instruction writes rd.
REQ-017 SHALL have port ext_stall  input  1  freeze all stages (e.g. memory busy).
REQ-018 SHALL have port flush  input  1  taken jump; kill young stages.
REQ-019 SHALL have port stage_valid  output  STAGES  bit k = stage k holds live instruction.
REQ-020 SHALL have ports stage_mc / stage_data / stage_pc  output  STAGES*MC_W / STAGES*DATA_W / STAGES*PC_W  stage k at [k*W +: W].
REQ-021 SHALL have port hazard  output  1  RAW dependency currently blocking issue.
REQ-022 SHALL have port hazard_cycles  output  16  saturating count of ticks lost to hazard.

Function
REQ-023 SHALL hold a divider counter 0..CE_DIV-1 that increments every clk and wraps; clk_enable = (counter == CE_DIV-1); CE_DIV=1 gives clk_enable constantly 1.
REQ-024 SHALL change stage registers only on clk edges where clk_enable=1 ("tick"); between ticks all outputs except clk_enable SHALL be stable.
REQ-025 SHALL assert hazard when a used source (issue_rs_use) matches rd of any stage k in 0..STAGES-2 with stage_valid[k]=1, rd_we=1, rd!=0; stage STAGES-1 (writeback) SHALL NOT cause hazard.
REQ-026 SHALL drive issue_ready = clk_enable & ~hazard & ~ext_stall & ~flush, combinationally.
REQ-027 On tick with ext_stall=0, flush=0: stage k+1 <= stage k for all k; s0 <= issued payload with valid=1 if issue_valid&issue_ready, else bubble.
REQ-028 Bubble SHALL be valid=0 with mc, data, pc, rd, rd_we all zero.
REQ-029 On tick with ext_stall=1, flush=0: all stages SHALL hold; no issue.
REQ-030 On tick with flush=1: stages 0..FLUSH_STAGE-1 SHALL become bubbles; stages >= FLUSH_STAGE SHALL shift per REQ-027 (or hold if ext_stall=1); no issue; flush beats ext_stall for the killed stages.
REQ-031 Instruction leaving stage STAGES-1 SHALL be discarded; no output beyond stage_* vectors.
REQ-032 hazard_cycles SHALL increment by 1 on each tick where issue_valid=1 and hazard=1 and ext_stall=0 and flush=0, saturating at 16'hFFFF.
REQ-033 flush or ext_stall outside a tick SHALL have no effect on state.

Reset
REQ-034 rst_n=0 SHALL immediately clear divider counter, all stage registers to bubble (stage_valid=0, payload 0), hazard_cycles=0; clk_enable=0 during reset unless CE_DIV=1.
REQ-035 After rst_n rises, first tick SHALL occur on the CE_DIV-th rising edge; reset asserted mid-stream SHALL discard all in-flight instructions.

Verification
REQ-036 CE_DIV=2, continuous independent issues pc=1,2,3,4 -> clk_enable toggles 0,1,0,1; pc=1 reaches s3 on 4th tick; stage_valid=4'b1111 after 4th tick.
REQ-037 Issue rd=5 rd_we=1 then rs1=5 use=01 -> hazard=1, issue_ready=0 for 3 ticks (rd in s0,s1,s2), bubble inserted each, hazard_cycles=3, accepted when producer reaches s3.
REQ-038 rd=0 producer followed by rs1=0 consumer -> hazard=0, back-to-back issue, hazard_cycles stays 0.
REQ-039 Full pipe, flush on tick, FLUSH_STAGE=2 -> s0,s1,s2 bubbles after tick (s0 new bubble, s1/s2 from killed s0/s1), s3 holds old s2 instruction.
REQ-040 ext_stall=1 for 5 ticks with pipe full -> stage_* unchanged, issue_ready=0, hazard_cycles unchanged; resumes exact order after release.
REQ-041 rst_n pulsed low mid-pipeline between ticks -> stage_valid=0 and hazard_cycles=0 within same cycle, no clk edge required; force hazard_cycles near max -> saturates at 16'hFFFF.
